lc3_fetch_stage: RTL and testbench
==================================

// Module: lc3_fetch_stage
// PURPOSE
//  - Instruction-fetch stage of the LC3 pipeline, directly upstream of the decode stage.
//  - Owns the PC and issues reads to instruction memory (1-cycle read latency).
//  - Drives the decode inputs npc_in, Instr_dout and enable_decode.
//  - Squashes the in-flight fetch on a taken branch.
// PARAMETERS
//  - PC_RESET  16'h3000  PC value loaded on reset
//  - ADDR_W    16        PC / address / instruction width (fixed 16 for LC3)
// PORTS
//  - clock            in   1       single clock; all state updates on posedge
//  - reset            in   1       synchronous, active-high reset
//  - enable_updatePC  in   1       controller: advance or redirect PC this cycle
//  - enable_fetch     in   1       controller: issue an imem read this cycle
//  - br_taken         in   1       branch resolved taken; valid only with enable_updatePC
//  - taddr            in   16      branch target
//  - imem_dout        in   16      imem read data, valid 1 cycle after imem_rd
//  - imem_rd          out  1       imem read strobe
//  - imem_addr        out  16      imem read address (= pc)
//  - pc               out  16      current PC
//  - npc_in           out  16      PC+1 of the instruction presented to decode
//  - Instr_dout       out  16      instruction presented to decode
//  - enable_decode    out  1       Instr_dout/npc_in valid this cycle
// BEHAVIOUR
//  - Reset: pc=PC_RESET; imem_rd=0; enable_decode=0; npc_in=0; Instr_dout=0; state=S_BOOT; perf counters=0.
//  - Reset dominates every other input in the same cycle; mid-operation reset discards any in-flight request.
//  - FSM states:
//    - S_BOOT: imem_rd=0; always -> S_RUN next cycle.
//    - S_RUN: imem_rd=enable_fetch; on (br_taken & enable_updatePC) -> S_FLUSH, else stay.
//    - S_FLUSH: one cycle; imem_rd=enable_fetch (address already = taddr); -> S_RUN.
//      A further taken branch here re-enters S_FLUSH.
//  - PC update: if enable_updatePC, pc <= br_taken ? taddr : pc+1.
//    - Modulo 2^16: 16'hFFFF+1 = 16'h0000.
//    - Otherwise pc holds. pc updates irrespective of enable_fetch.
//  - imem_addr = pc (combinational).
//  - Request tracking: req_v_q <= imem_rd & ~(br_taken & enable_updatePC); req_npc_q <= pc+1.
//  - Latency: request issued in cycle N; enable_decode=req_v_q in N+1, with Instr_dout=imem_dout and npc_in=req_npc_q.
//  - enable_decode=0: Instr_dout and npc_in hold the last valid values (hold register).
//  - Squash: a taken branch in cycle N kills the request issued in N, so enable_decode=0 in N+1.
//  - Stall: enable_fetch=0 in N -> imem_rd=0 in N -> enable_decode=0 in N+1. No replay; the controller re-asserts.
// CONFIGURATION
//  - Macro LC3_FETCH_PERF_EN. Defined:
//    - extra outputs fetch_cnt[31:0] (+1 per cycle enable_decode=1) and squash_cnt[15:0] (+1 per squashed request).
//    - Both saturate at all-ones and clear on reset.
//  - Undefined: ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  - lc3_pkg:
//    - typedef enum logic [1:0] {S_BOOT,S_RUN,S_FLUSH} fetch_state_t
//    - typedef logic [15:0] lc3_word_t
//    - localparam lc3_word_t LC3_PC_RESET = 16'h3000
//  - Sub-module lc3_pc_reg: PC register with increment/redirect/reset. The rest (FSM, request tracking, hold regs, perf) stays in lc3_fetch_stage.
// TESTING
//  - Reset released, enable_fetch=enable_updatePC=1:
//    - cycle 1: pc=3000, imem_rd=0
//    - cycle 2: imem_addr=3000, imem_rd=1
//    - cycle 3: enable_decode=1, npc_in=3001, Instr_dout=imem data @3000
//  - Sequential run of 4 instrs:
//    - npc_in sequence 3001,3002,3003,3004 on consecutive cycles
//    - the decode monitor sees 4 transactions in order
//  - Taken branch to taddr=3100 while fetching 3005:
//    - next cycle enable_decode=0 (squashed)
//    - following cycle npc_in=3101; with LC3_FETCH_PERF_EN, squash_cnt=1
//  - Stall enable_fetch=0 for 3 cycles (enable_updatePC=0):
//    - enable_decode=0 for 3 cycles; npc_in/Instr_dout held; pc unchanged
//    - resumes with no lost or duplicated instruction
//  - Wrap: pc=FFFF with enable_updatePC=1 -> pc=0000; decode sees npc_in=0000 for the FFFF instruction.
//  - Mid-run reset with a request in flight:
//    - next cycle enable_decode=0, pc=3000, state=S_BOOT
//    - the stale imem_dout is never presented to decode

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared types and constants for the LC3 fetch stage.
//   fetch_state_t : fetch FSM state encoding
//   lc3_word_t    : 16-bit LC3 machine word
//   LC3_PC_RESET  : PC value loaded on reset
package lc3_pkg;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } fetch_state_t;

    typedef logic [15:0] lc3_word_t;

    localparam lc3_word_t LC3_PC_RESET = 16'h3000;

endpackage

// File: rtl/lc3_pc_reg.sv
// LC3 program counter register.
//   i_clk       : clock, state updates on posedge
//   i_rst       : synchronous active-high reset, loads PC_RESET
//   i_update    : advance (pc+1) or redirect (taddr) this cycle
//   i_br_taken  : select i_taddr instead of pc+1 when i_update is set
//   i_taddr     : branch target
//   o_pc        : current PC
//   o_pc_inc    : pc+1, modulo 2^ADDR_W
module lc3_pc_reg
    import lc3_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]  PC_RESET = LC3_PC_RESET
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_update,
    input  logic              i_br_taken,
    input  logic [ADDR_W-1:0] i_taddr,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_pc_inc
);

    logic [ADDR_W-1:0] r_pc;

    // Natural overflow gives the required FFFF -> 0000 wrap.
    assign o_pc_inc = r_pc + ADDR_W'(1);
    assign o_pc     = r_pc;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc <= PC_RESET;
        end else if (i_update) begin
            r_pc <= i_br_taken ? i_taddr : o_pc_inc;
        end
    end

endmodule

// File: rtl/lc3_fetch_stage.sv
// LC3 instruction-fetch stage: owns the PC, issues imem reads (1-cycle latency)
// and presents fetched instructions to decode. A taken branch squashes the
// read issued in the same cycle.
// Optional build macro: LC3_FETCH_PERF_EN adds fetch_cnt / squash_cnt.
// Ports:
//   clock, reset        : clock and synchronous active-high reset
//   enable_updatePC     : advance or redirect PC this cycle
//   enable_fetch        : issue an imem read this cycle
//   br_taken, taddr     : taken-branch indication and target
//   imem_dout           : imem read data, valid one cycle after imem_rd
//   imem_rd, imem_addr  : imem read strobe and address (= pc)
//   pc                  : current PC
//   npc_in, Instr_dout  : PC+1 and instruction presented to decode
//   enable_decode       : npc_in / Instr_dout valid this cycle
//   fetch_cnt           : (perf) cycles with enable_decode=1, saturating
//   squash_cnt          : (perf) squashed requests, saturating
module lc3_fetch_stage
    import lc3_pkg::*;
#(
    parameter lc3_word_t   PC_RESET = LC3_PC_RESET,
    parameter int unsigned ADDR_W   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable_updatePC,
    input  logic              enable_fetch,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] taddr,
    input  logic [ADDR_W-1:0] imem_dout,
    output logic              imem_rd,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] npc_in,
    output logic [ADDR_W-1:0] Instr_dout,
    output logic              enable_decode
`ifdef LC3_FETCH_PERF_EN
    ,
    output logic [31:0]       fetch_cnt,
    output logic [15:0]       squash_cnt
`endif
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_next;
    logic              w_active;
    logic              w_pc_update;
    logic              w_taken;
    logic [ADDR_W-1:0] w_pc;
    logic [ADDR_W-1:0] w_pc_inc;

    logic              r_req_v;
    logic [ADDR_W-1:0] r_req_npc;
    logic [ADDR_W-1:0] r_npc_hold;
    logic [ADDR_W-1:0] r_instr_hold;

    // The PC is frozen during the boot cycle so the first read targets PC_RESET.
    assign w_active    = (r_state != S_BOOT);
    assign w_pc_update = enable_updatePC & w_active;
    assign w_taken     = br_taken & w_pc_update;

    lc3_pc_reg #(
        .ADDR_W   (ADDR_W),
        .PC_RESET (PC_RESET)
    ) u_pc_reg (
        .i_clk      (clock),
        .i_rst      (reset),
        .i_update   (w_pc_update),
        .i_br_taken (br_taken),
        .i_taddr    (taddr),
        .o_pc       (w_pc),
        .o_pc_inc   (w_pc_inc)
    );

    assign pc        = w_pc;
    assign imem_addr = w_pc;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        imem_rd      = 1'b0;
        unique case (r_state)
            S_BOOT: begin
                w_state_next = S_RUN;
            end
            S_RUN, S_FLUSH: begin
                imem_rd      = enable_fetch;
                w_state_next = w_taken ? S_FLUSH : S_RUN;
            end
            default: begin
                w_state_next = S_BOOT;
            end
        endcase
    end

    // Request tracking plus hold registers that keep the last presented
    // instruction visible while decode is idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_req_v      <= 1'b0;
            r_req_npc    <= '0;
            r_npc_hold   <= '0;
            r_instr_hold <= '0;
        end else begin
            r_req_v   <= imem_rd & ~w_taken;
            r_req_npc <= w_pc_inc;
            if (r_req_v) begin
                r_npc_hold   <= r_req_npc;
                r_instr_hold <= imem_dout;
            end
        end
    end

    assign enable_decode = r_req_v;
    assign npc_in        = r_req_v ? r_req_npc : r_npc_hold;
    assign Instr_dout    = r_req_v ? imem_dout : r_instr_hold;

`ifdef LC3_FETCH_PERF_EN
    logic [31:0] r_fetch_cnt;
    logic [15:0] r_squash_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_cnt  <= '0;
            r_squash_cnt <= '0;
        end else begin
            if (r_req_v && (r_fetch_cnt != '1)) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (imem_rd && w_taken && (r_squash_cnt != '1)) begin
                r_squash_cnt <= r_squash_cnt + 16'd1;
            end
        end
    end

    assign fetch_cnt  = r_fetch_cnt;
    assign squash_cnt = r_squash_cnt;
`endif

endmodule

// File: tb/tb_lc3_fetch_stage.sv
// Self-checking bench for lc3_fetch_stage: a per-cycle vector table gives the
// inputs and the expected visible outputs; a scoreboard queue collects the
// decode transactions each non-squashed read must produce and is drained as
// enable_decode fires.
module tb_lc3_fetch_stage;

    logic        clock;
    logic        reset;
    logic        enable_updatePC;
    logic        enable_fetch;
    logic        br_taken;
    logic [15:0] taddr;
    logic [15:0] imem_dout;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic [15:0] pc;
    logic [15:0] npc_in;
    logic [15:0] Instr_dout;
    logic        enable_decode;
`ifdef LC3_FETCH_PERF_EN
    logic [31:0] fetch_cnt;
    logic [15:0] squash_cnt;
`endif

    lc3_fetch_stage dut (
        .clock           (clock),
        .reset           (reset),
        .enable_updatePC (enable_updatePC),
        .enable_fetch    (enable_fetch),
        .br_taken        (br_taken),
        .taddr           (taddr),
        .imem_dout       (imem_dout),
        .imem_rd         (imem_rd),
        .imem_addr       (imem_addr),
        .pc              (pc),
        .npc_in          (npc_in),
        .Instr_dout      (Instr_dout),
        .enable_decode   (enable_decode)
`ifdef LC3_FETCH_PERF_EN
        ,
        .fetch_cnt       (fetch_cnt),
        .squash_cnt      (squash_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [15:0] memf(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A5A;
    endfunction

    // 1-cycle-latency imem; non-read cycles return a recognisable junk word.
    initial imem_dout = 16'h0000;
    always @(posedge clock) imem_dout <= imem_rd ? memf(imem_addr) : 16'hDEAD;

    typedef struct {
        logic        rst;
        logic        upd;
        logic        fetch;
        logic        br;
        logic [15:0] taddr;
        logic [15:0] pc;
        logic        rd;
        logic        dec;
        logic [15:0] npc;
        logic [15:0] ins;
    } vec_t;

    typedef struct {
        logic [15:0] npc;
        logic [15:0] ins;
    } txn_t;

    vec_t vecs[$];
    txn_t sb[$];
    int   n_checks;
    int   n_fail;
    int   sq_row;

    task automatic add(input logic rst, input logic upd, input logic fetch, input logic br,
                       input logic [15:0] ta, input logic [15:0] epc, input logic erd,
                       input logic edec, input logic [15:0] enpc, input logic [15:0] eins);
        vec_t v;
        v.rst = rst; v.upd = upd; v.fetch = fetch; v.br = br; v.taddr = ta;
        v.pc = epc; v.rd = erd; v.dec = edec; v.npc = enpc; v.ins = eins;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int row, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, got, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        sq_row   = -1;

        //   rst upd fch br  taddr     pc        rd  dec npc       ins
        add(1, 1, 1, 0, 16'h0000, 16'h3000, 0, 0, 16'h0000, 16'h0000);
        add(1, 1, 1, 0, 16'h0000, 16'h3000, 0, 0, 16'h0000, 16'h0000);
        // boot cycle, then sequential fetch 3000..3004
        add(0, 1, 1, 0, 16'h0000, 16'h3000, 0, 0, 16'h0000, 16'h0000);
        add(0, 1, 1, 0, 16'h0000, 16'h3000, 1, 0, 16'h0000, 16'h0000);
        add(0, 1, 1, 0, 16'h0000, 16'h3001, 1, 1, 16'h3001, memf(16'h3000));
        add(0, 1, 1, 0, 16'h0000, 16'h3002, 1, 1, 16'h3002, memf(16'h3001));
        add(0, 1, 1, 0, 16'h0000, 16'h3003, 1, 1, 16'h3003, memf(16'h3002));
        add(0, 1, 1, 0, 16'h0000, 16'h3004, 1, 1, 16'h3004, memf(16'h3003));
        // taken branch to 3100 while fetching 3005
        add(0, 1, 1, 1, 16'h3100, 16'h3005, 1, 1, 16'h3005, memf(16'h3004));
        sq_row = vecs.size();
        add(0, 1, 1, 0, 16'h0000, 16'h3100, 1, 0, 16'h3005, memf(16'h3004));
        add(0, 1, 1, 0, 16'h0000, 16'h3101, 1, 1, 16'h3101, memf(16'h3100));
        // three stall cycles, then resume
        add(0, 0, 0, 0, 16'h0000, 16'h3102, 0, 1, 16'h3102, memf(16'h3101));
        add(0, 0, 0, 0, 16'h0000, 16'h3102, 0, 0, 16'h3102, memf(16'h3101));
        add(0, 0, 0, 0, 16'h0000, 16'h3102, 0, 0, 16'h3102, memf(16'h3101));
        add(0, 1, 1, 0, 16'h0000, 16'h3102, 1, 0, 16'h3102, memf(16'h3101));
        // branch to FFFF, then wrap to 0000
        add(0, 1, 1, 1, 16'hFFFF, 16'h3103, 1, 1, 16'h3103, memf(16'h3102));
        add(0, 1, 1, 0, 16'h0000, 16'hFFFF, 1, 0, 16'h3103, memf(16'h3102));
        // taken branch in RUN, then another taken branch while in FLUSH
        add(0, 1, 1, 1, 16'h2000, 16'h0000, 1, 1, 16'h0000, memf(16'hFFFF));
        add(0, 1, 1, 1, 16'h2100, 16'h2000, 1, 0, 16'h0000, memf(16'hFFFF));
        add(0, 1, 1, 0, 16'h0000, 16'h2100, 1, 0, 16'h0000, memf(16'hFFFF));
        add(0, 1, 1, 0, 16'h0000, 16'h2101, 1, 1, 16'h2101, memf(16'h2100));
        // reset with a request in flight; its data must never reach decode
        add(1, 1, 1, 0, 16'h0000, 16'h2102, 1, 1, 16'h2102, memf(16'h2101));
        add(0, 1, 1, 0, 16'h0000, 16'h3000, 0, 0, 16'h0000, 16'h0000);
        add(0, 1, 1, 0, 16'h0000, 16'h3000, 1, 0, 16'h0000, 16'h0000);
        // PC advances even with enable_fetch low
        add(0, 1, 0, 0, 16'h0000, 16'h3001, 0, 1, 16'h3001, memf(16'h3000));
        add(0, 0, 0, 0, 16'h0000, 16'h3002, 0, 0, 16'h3001, memf(16'h3000));

        reset           = 1'b1;
        enable_updatePC = 1'b0;
        enable_fetch    = 1'b0;
        br_taken        = 1'b0;
        taddr           = 16'h0000;
        @(posedge clock);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            reset           = vecs[i].rst;
            enable_updatePC = vecs[i].upd;
            enable_fetch    = vecs[i].fetch;
            br_taken        = vecs[i].br;
            taddr           = vecs[i].taddr;
            @(negedge clock);
            check("pc", i, {16'h0, pc}, {16'h0, vecs[i].pc});
            check("imem_addr", i, {16'h0, imem_addr}, {16'h0, vecs[i].pc});
            check("imem_rd", i, {31'h0, imem_rd}, {31'h0, vecs[i].rd});
            check("enable_decode", i, {31'h0, enable_decode}, {31'h0, vecs[i].dec});
            check("npc_in", i, {16'h0, npc_in}, {16'h0, vecs[i].npc});
            check("Instr_dout", i, {16'h0, Instr_dout}, {16'h0, vecs[i].ins});
`ifdef LC3_FETCH_PERF_EN
            if (i == sq_row) check("squash_cnt", i, {16'h0, squash_cnt}, 32'd1);
`endif
            // Scoreboard: pop on every decode beat, push for every surviving read.
            if (enable_decode === 1'b1) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_decode", i, 32'd1, 32'd0);
                end else begin
                    txn_t t;
                    t = sb.pop_front();
                    check("sb_npc", i, {16'h0, npc_in}, {16'h0, t.npc});
                    check("sb_instr", i, {16'h0, Instr_dout}, {16'h0, t.ins});
                end
            end
            if (vecs[i].rd && !vecs[i].rst && !(vecs[i].br && vecs[i].upd)) begin
                txn_t t;
                t.npc = vecs[i].pc + 16'd1;
                t.ins = memf(vecs[i].pc);
                sb.push_back(t);
            end
            @(posedge clock);
            #1;
        end

        check("sb_leftover", vecs.size(), sb.size(), 32'd0);
`ifdef LC3_FETCH_PERF_EN
        check("fetch_cnt_end", vecs.size(), fetch_cnt, 32'd1);
        check("squash_cnt_end", vecs.size(), {16'h0, squash_cnt}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
